// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

    // Operand select encodings for the EX-stage operand muxes
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Architectural PC lives in r15 and is never a forwarding target
    localparam logic [3:0] PC_REG = 4'd15;

    // Wait counter wide enough for the largest legal timeout (255)
    localparam int WAIT_CNT_W = 8;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forwarding compare for one EX-stage source operand.
// Latency: combinational.
// Backpressure: none; pure function of the current stage contents.
//
// Ports:
//   ra_e          source register of the EX instruction
//   wa3_m, wa3_w  destination registers in MEM and WB
//   wr_m, wr_w    validity-qualified write enables for MEM and WB
//   fwd_sel       FWD_RF / FWD_WB / FWD_MEM
module hazard_fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [3:0] ra_e,
    input  logic [3:0] wa3_m,
    input  logic [3:0] wa3_w,
    input  logic       wr_m,
    input  logic       wr_w,
    output logic [1:0] fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (ra_e != PC_REG) begin
            // MEM holds the younger result, so it wins over WB
            if (wr_m && (wa3_m == ra_e)) begin
                fwd_sel = FWD_MEM;
            end else if (wr_w && (wa3_w == ra_e)) begin
                fwd_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward sequencing and per-stage valid tracking for the 5-stage core.
// Latency: controls are combinational; valid bits and wait FSM update on the next edge.
// Backpressure: a data-memory wait stalls all stages; watchdog expiry freezes the pipe until reset.
//
// Ports: clk, reset (sync, active-high); RA*/WA3*/RegWrite*/MemtoRegE/MispredictE from the
// stage registers; dmem_req/dmem_ready from data memory; Stall*/Flush* to the stage registers;
// ForwardAE/BE to the EX operand muxes; validE/M/W gate downstream writes; mem_err sticky.
// Optional build macro HAZARD_PERF_EN adds perf_stall/perf_lduse/perf_flush (CNT_W bits, saturating).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] RA1D,
    input  logic [3:0] RA2D,
    input  logic [3:0] RA1E,
    input  logic [3:0] RA2E,
    input  logic [3:0] WA3E,
    input  logic [3:0] WA3M,
    input  logic [3:0] WA3W,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       MispredictE,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       validE,
    output logic       validM,
    output logic       validW,
    output logic       mem_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_lduse,
    output logic [CNT_W-1:0] perf_flush
`endif
);

    if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_param_chk
        $error("hazard_ctrl: MEM_TIMEOUT must be 2..255 and CNT_W at least 1");
    end

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);

    state_t                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    valid_d_q, valid_d_d;
    logic                    valid_e_q, valid_e_d;
    logic                    valid_m_q, valid_m_d;
    logic                    valid_w_q, valid_w_d;

    logic wr_e, wr_m, wr_w;
    logic lduse, mispredict, memwait;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
    logic [1:0] fwd_a, fwd_b;

    // Raw write flags only count when the stage holds a live instruction
    assign wr_e = RegWriteE & valid_e_q;
    assign wr_m = RegWriteM & valid_m_q;
    assign wr_w = RegWriteW & valid_w_q;

    assign lduse      = MemtoRegE & wr_e & ((WA3E == RA1D) | (WA3E == RA2D)) & valid_d_q;
    assign mispredict = MispredictE & valid_e_q;
    assign memwait    = valid_m_q & dmem_req & ~dmem_ready;

    hazard_fwd_unit u_fwd_a (
        .ra_e    (RA1E),
        .wa3_m   (WA3M),
        .wa3_w   (WA3W),
        .wr_m    (wr_m),
        .wr_w    (wr_w),
        .fwd_sel (fwd_a)
    );

    hazard_fwd_unit u_fwd_b (
        .ra_e    (RA2E),
        .wa3_m   (WA3M),
        .wa3_w   (WA3W),
        .wr_m    (wr_m),
        .wr_w    (wr_w),
        .fwd_sel (fwd_b)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        stall_m    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;

        // wait_cnt counts memwait cycles of the current access, including the first
        case (state_q)
            RUN: begin
                if (memwait) begin
                    state_d    = WAIT;
                    wait_cnt_d = WAIT_CNT_W'(1);
                end
            end
            WAIT: begin
                // Leaving on !memwait (not just dmem_ready) keeps the FSM aligned with the stalls
                if (!memwait) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                    if (wait_cnt_d == TIMEOUT_CNT) begin
                        state_d = ERR;
                    end
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase

        // A mispredict beats load-use: the stalled ID instruction would be squashed anyway
        if (reset) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (state_q == ERR || memwait) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (mispredict) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lduse) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end

        // Fetch is always live, so an unstalled, unflushed ID fills with a valid instruction
        valid_d_d = flush_d ? 1'b0 : (stall_d ? valid_d_q : 1'b1);
        valid_e_d = flush_e ? 1'b0 : (stall_e ? valid_e_q : valid_d_q);
        valid_m_d = stall_m ? valid_m_q : valid_e_q;
        // WB receives a bubble while MEM is held
        valid_w_d = stall_m ? 1'b0 : valid_m_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            valid_d_q  <= 1'b0;
            valid_e_q  <= 1'b0;
            valid_m_q  <= 1'b0;
            valid_w_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            valid_d_q  <= valid_d_d;
            valid_e_q  <= valid_e_d;
            valid_m_q  <= valid_m_d;
            valid_w_q  <= valid_w_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
    logic [CNT_W-1:0] perf_lduse_q, perf_lduse_d;
    logic [CNT_W-1:0] perf_flush_q, perf_flush_d;
    logic             live;

    // Events are counted only when they actually drive the controls
    assign live = ~reset & (state_q != ERR);

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_lduse_d = perf_lduse_q;
        perf_flush_d = perf_flush_q;
        if (live && memwait && perf_stall_q != '1) begin
            perf_stall_d = perf_stall_q + CNT_W'(1);
        end
        if (live && !memwait && mispredict && perf_flush_q != '1) begin
            perf_flush_d = perf_flush_q + CNT_W'(1);
        end
        if (live && !memwait && !mispredict && lduse && perf_lduse_q != '1) begin
            perf_lduse_d = perf_lduse_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_lduse_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_lduse_q <= perf_lduse_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_lduse = perf_lduse_q;
    assign perf_flush = perf_flush_q;
`endif

    assign StallF    = stall_f;
    assign StallD    = stall_d;
    assign StallE    = stall_e;
    assign StallM    = stall_m;
    assign FlushD    = flush_d;
    assign FlushE    = flush_e;
    assign ForwardAE = reset ? FWD_RF : fwd_a;
    assign ForwardBE = reset ? FWD_RF : fwd_b;
    assign validE    = valid_e_q;
    assign validM    = valid_m_q;
    assign validW    = valid_w_q;
    assign mem_err   = (state_q == ERR) & ~reset;

endmodule
